// File: rtl/st_phase_if.sv
// Coil-line taps, clear pulses and decoded results shared between the phase
// decoder and whatever observes it.
interface st_phase_if #(
  parameter int POS_W = 16,
  parameter int PER_W = 16
);
  logic             a1, a2, b1, b2;
  logic             pos_clr, err_clr;
  logic [POS_W-1:0] pos;
  logic             dir, step_stb, locked, stall;
  logic [PER_W-1:0] period;
  logic             per_vld, err_skip, err_illegal;

  modport master (
    output a1, a2, b1, b2, pos_clr, err_clr,
    input  pos, dir, step_stb, locked, stall, period, per_vld, err_skip, err_illegal
  );

  modport slave (
    input  a1, a2, b1, b2, pos_clr, err_clr,
    output pos, dir, step_stb, locked, stall, period, per_vld, err_skip, err_illegal
  );
endinterface

// File: rtl/st_phase_decoder.sv
// Unipolar stepper monitor: filters the coil lines on a prescaled tick and turns
// full-step phase changes into step pulses, position, period, stall and error flags.
//
// state       | meaning
// ST_UNLOCKED | no legal phase accepted since reset, OFF or an illegal pattern
// ST_LOCKED   | last accepted pattern is a legal phase; phase changes count as steps
module st_phase_decoder #(
  parameter int DIV         = 4096,
  parameter int FILT        = 8,
  parameter int STALL_TICKS = 24414,
  parameter int POS_W       = 16,
  parameter int PER_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  st_phase_if.slave   bus
);

  localparam int                PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int                STL_W    = $clog2(STALL_TICKS + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [7:0]        FILT_N   = 8'(FILT);
  localparam logic [STL_W-1:0]  STALL_N  = STL_W'(STALL_TICKS);

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_t;

  // {legal, index} for a coil vector {B2,B1,A2,A1}
  function automatic logic [2:0] phase_of(input logic [3:0] v);
    case (v)
      4'b0110: phase_of = 3'b100;
      4'b0011: phase_of = 3'b101;
      4'b1001: phase_of = 3'b110;
      4'b1100: phase_of = 3'b111;
      default: phase_of = 3'b000;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         sync1_q, sync2_q;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [3:0]         cand_q, cand_d, acc_q, acc_d;
  logic [7:0]         stab_q, stab_d;
  logic [1:0]         idx_q, idx_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_q, dir_d, stb_q, stb_d, stall_q, stall_d;
  logic [STL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [PER_W-1:0]   period_q, period_d, per_cnt_q, per_cnt_d;
  logic               per_vld_q, per_vld_d, have_q, have_d;
  logic               skip_q, skip_d, ill_q, ill_d;

  logic               tick, accept, step_fwd, step_rev, step;
  logic [2:0]         ph;
  logic [1:0]         diff;

  always_comb begin
    tick        = (presc_q == PRE_LAST);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    state_d     = state_q;
    cand_d      = cand_q;
    stab_d      = stab_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    stb_d       = 1'b0;
    stall_d     = stall_q;
    stall_cnt_d = stall_cnt_q;
    period_d    = period_q;
    per_vld_d   = per_vld_q;
    per_cnt_d   = per_cnt_q;
    have_d      = have_q;
    skip_d      = skip_q;
    ill_d       = ill_q;
    accept      = 1'b0;
    step_fwd    = 1'b0;
    step_rev    = 1'b0;

    // clear first so a same-cycle error set below wins
    if (bus.err_clr) begin
      skip_d = 1'b0;
      ill_d  = 1'b0;
    end

    if (tick) begin
      if (sync2_q == cand_q) begin
        if (stab_q < FILT_N) stab_d = stab_q + 8'd1;
      end else begin
        cand_d = sync2_q;
        stab_d = 8'd1;
      end
      accept = (stab_d == FILT_N) && (cand_d != acc_q);
    end

    ph   = phase_of(cand_d);
    diff = ph[1:0] - idx_q;

    if (accept) begin
      acc_d = cand_d;
      if (ph[2]) begin
        idx_d = ph[1:0];
        if (state_q == ST_UNLOCKED) begin
          state_d   = ST_LOCKED;
          per_vld_d = 1'b0;
          have_d    = 1'b0;
        end else begin
          case (diff)
            2'd1:    step_fwd = 1'b1;
            2'd3:    step_rev = 1'b1;
            2'd2:    skip_d   = 1'b1;
            default: ;
          endcase
        end
      end else begin
        state_d = ST_UNLOCKED;
        if (cand_d != 4'b0000) ill_d = 1'b1;
      end
    end

    step = step_fwd | step_rev;
    if (step) begin
      pos_d  = step_fwd ? pos_q + 1'b1 : pos_q - 1'b1;
      dir_d  = step_rev;
      stb_d  = 1'b1;
      if (have_q) begin
        period_d  = per_cnt_q;
        per_vld_d = 1'b1;
      end
      have_d    = 1'b1;
      per_cnt_d = PER_W'(1);
    end else if (tick && (per_cnt_q != '1)) begin
      per_cnt_d = per_cnt_q + 1'b1;
    end

    if (tick) begin
      if ((state_q != ST_LOCKED) || step) stall_cnt_d = '0;
      else if (stall_cnt_q != STALL_N)    stall_cnt_d = stall_cnt_q + 1'b1;
      if ((state_q == ST_LOCKED) && !step && (stall_cnt_d == STALL_N)) stall_d = 1'b1;
    end
    if ((state_d == ST_UNLOCKED) || step) stall_d = 1'b0;

    if (bus.pos_clr) pos_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      sync1_q     <= '0;
      sync2_q     <= '0;
      presc_q     <= '0;
      cand_q      <= '0;
      stab_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      pos_q       <= '0;
      dir_q       <= 1'b0;
      stb_q       <= 1'b0;
      stall_q     <= 1'b0;
      stall_cnt_q <= '0;
      period_q    <= '0;
      per_vld_q   <= 1'b0;
      per_cnt_q   <= '0;
      have_q      <= 1'b0;
      skip_q      <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= {bus.b2, bus.b1, bus.a2, bus.a1};
      sync2_q     <= sync1_q;
      presc_q     <= presc_d;
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      stb_q       <= stb_d;
      stall_q     <= stall_d;
      stall_cnt_q <= stall_cnt_d;
      period_q    <= period_d;
      per_vld_q   <= per_vld_d;
      per_cnt_q   <= per_cnt_d;
      have_q      <= have_d;
      skip_q      <= skip_d;
      ill_q       <= ill_d;
    end
  end

  assign bus.pos         = pos_q;
  assign bus.dir         = dir_q;
  assign bus.step_stb    = stb_q;
  assign bus.locked      = (state_q == ST_LOCKED);
  assign bus.stall       = stall_q;
  assign bus.period      = period_q;
  assign bus.per_vld     = per_vld_q;
  assign bus.err_skip    = skip_q;
  assign bus.err_illegal = ill_q;

endmodule
